// File: rtl/turn_sequencer_if.sv
// Player-side handshake bundle for turn_sequencer: one valid/action/ready
// channel per player.
interface turn_sequencer_if;
    logic       p1Valid;
    logic [2:0] p1Action;
    logic       p1Ready;
    logic       p2Valid;
    logic [2:0] p2Action;
    logic       p2Ready;

    modport master (
        output p1Valid, p1Action, p2Valid, p2Action,
        input  p1Ready, p2Ready
    );

    modport slave (
        input  p1Valid, p1Action, p2Valid, p2Action,
        output p1Ready, p2Ready
    );
endinterface

// File: rtl/turn_sequencer.sv
// Collects one action per player, closes the turn on double commit or timer
// expiry, and strobes the action pair into the game core until a winner exists.
module turn_sequencer #(
    parameter int unsigned TURN_TIMEOUT   = 8,
    parameter logic [2:0]  DEFAULT_ACTION = 3'b000
) (
    input  logic                    clk,
    input  logic                    resetGame,
    turn_sequencer_if.slave         players,
    input  logic                    firstWin,
    input  logic                    secondWin,
    output logic [2:0]              action1,
    output logic [2:0]              action2,
    output logic                    actionEnable,
    output logic [7:0]              turnCount
);

    typedef enum logic [1:0] {COLLECT, ISSUE, GAP, OVER} state_t;

    state_t     state, state_next;
    logic       committed1, committed2;
    logic [2:0] slot1, slot2;
    logic [7:0] timer;

    logic       game_won;
    logic       accept1, accept2;
    logic       has1, has2;
    logic [2:0] pick1, pick2;
    logic       expired;
    logic       issue_go;

    assign game_won = firstWin || secondWin;

    // Readies are gated by reset so neither player sees an open slot while held.
    assign players.p1Ready = resetGame && (state == COLLECT) && !committed1 && !game_won;
    assign players.p2Ready = resetGame && (state == COLLECT) && !committed2 && !game_won;

    assign accept1 = players.p1Valid && players.p1Ready;
    assign accept2 = players.p2Valid && players.p2Ready;
    assign has1    = committed1 || accept1;
    assign has2    = committed2 || accept2;
    assign pick1   = accept1 ? players.p1Action : slot1;
    assign pick2   = accept2 ? players.p2Action : slot2;
    assign expired = (timer == 8'(TURN_TIMEOUT - 1));

    assign issue_go = (state == COLLECT) && !game_won &&
                      ((has1 && has2) || (expired && (has1 || has2)));

    // NOTE: state_next is assigned before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            COLLECT: begin
                if (game_won)      state_next = OVER;
                else if (issue_go) state_next = ISSUE;
            end
            ISSUE:   state_next = game_won ? OVER : GAP;
            GAP:     state_next = game_won ? OVER : COLLECT;
            OVER:    state_next = OVER;
            default: state_next = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetGame) state <= COLLECT;
        else            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!resetGame) begin
            committed1   <= 1'b0;
            committed2   <= 1'b0;
            // NOTE: the action slots are reset too, so a reset discards any half-collected turn.
            slot1        <= DEFAULT_ACTION;
            slot2        <= DEFAULT_ACTION;
            timer        <= 8'd0;
            action1      <= DEFAULT_ACTION;
            action2      <= DEFAULT_ACTION;
            actionEnable <= 1'b0;
            turnCount    <= 8'd0;
        end else begin
            actionEnable <= issue_go;
            if (issue_go) begin
                action1   <= has1 ? pick1 : DEFAULT_ACTION;
                action2   <= has2 ? pick2 : DEFAULT_ACTION;
                turnCount <= turnCount + 8'd1;
            end

            if (state == COLLECT && !issue_go && !game_won) begin
                committed1 <= has1;
                committed2 <= has2;
                if (accept1) slot1 <= players.p1Action;
                if (accept2) slot2 <= players.p2Action;
                // Expiry with nobody committed just restarts the window.
                timer <= expired ? 8'd0 : timer + 8'd1;
            end else begin
                committed1 <= 1'b0;
                committed2 <= 1'b0;
                timer      <= 8'd0;
            end
        end
    end

endmodule
